// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking neural network datapath.
// Imported by the neuron array, the spike FIFOs and the host bridge.
package snn_pkg;

  localparam int SNN_DATA_WIDTH = 16;
  localparam int SNN_ADDR_WIDTH = 7;

  typedef enum logic {
    DROP_NEW      = 1'b0,
    OVERWRITE_OLD = 1'b1
  } fifo_mode_e;

  // Maps the integer OVERWRITE parameter (0/1) onto the mode enum.
  function automatic fifo_mode_e mode_from_param(input int overwrite);
    return (overwrite != 0) ? OVERWRITE_OLD : DROP_NEW;
  endfunction

endpackage

// File: rtl/spike_fifo_ram.sv
// Simple dual-port storage for the spike FIFO: one write port and one
// registered read port that returns the new word on a same-address write.
module spike_fifo_ram
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = SNN_DATA_WIDTH,
  parameter int ADDR_WIDTH = SNN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // NOTE: the array has no reset; stale words are unreachable once the
  // pointers are cleared, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/spike_fifo_fwft.sv
// First-word-fall-through spike FIFO: sync-read RAM plus one output register
// that is refilled from the RAM prefetch or bypassed from data_in.
module spike_fifo_fwft
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = SNN_DATA_WIDTH,
  parameter int ADDR_WIDTH = SNN_ADDR_WIDTH,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_LVL = 4,
  parameter int OVERWRITE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int              DEPTH    = 1 << ADDR_WIDTH;
  localparam int              CW       = ADDR_WIDTH + 1;
  localparam fifo_mode_e      MODE     = mode_from_param(OVERWRITE);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_LVL);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] head_ptr;
  logic [ADDR_WIDTH-1:0] head_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  pop;
  logic                  push;
  logic                  advance;
  logic                  lost;
  logic                  load_ram;
  logic                  load_bypass;

  // ram_q always holds the entry behind the head (head_ptr + 1), so a pop
  // can refill the output register without a bubble.
  spike_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (push),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pop          = rd & valid;
    lost         = wr & fifo_full & ~pop;
    push         = wr & (~fifo_full | pop | (MODE == OVERWRITE_OLD));
    advance      = pop | (lost & (MODE == OVERWRITE_OLD));
    count_nxt    = count;
    head_ptr_nxt = head_ptr;
    load_ram     = 1'b0;
    load_bypass  = 1'b0;

    if (push && !advance) begin
      count_nxt = count + CNT_ONE;
    end else if (advance && !push) begin
      count_nxt = count - CNT_ONE;
    end

    if (advance) begin
      head_ptr_nxt = head_ptr + PTR_ONE;
    end
    rd_addr = head_ptr_nxt + PTR_ONE;

    // With two or more entries the successor is already in ram_q; with zero
    // or one entry the incoming word becomes the head directly.
    if (advance && (count > CNT_ONE)) begin
      load_ram = 1'b1;
    end else if (push && ((count == '0) || ((count == CNT_ONE) && advance))) begin
      load_bypass = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      head_ptr     <= '0;
      count        <= '0;
      data_out     <= '0;
      valid        <= 1'b0;
      fifo_full    <= 1'b0;
      almost_full  <= (AFULL_LVL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      head_ptr     <= head_ptr_nxt;
      count        <= count_nxt;
      valid        <= (count_nxt != '0);
      fifo_full    <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);

      if (load_ram) begin
        data_out <= ram_q;
      end else if (load_bypass) begin
        data_out <= data_in;
      end

      // A set event in the same cycle as clr_err wins over the clear.
      overflow  <= lost | (overflow & ~clr_err);
      underflow <= (rd & ~valid) | (underflow & ~clr_err);
    end
  end

endmodule
